// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared encodings for the iterative multiply/divide unit
package mul_div_unit_pkg;

  // Operation codes as presented on the op port
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  // Number of iteration edges per operation (one per operand bit)
  localparam int ITER = 32;

  // Signed variants negate operands by their sign bit; unsigned ones use raw values
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between control stage and multiply/divide unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  // Control stage side: issues requests, consumes results
  modport master (
    output A, B, op, start,
    input  busy, done, hi, lo, div_by_zero
  );

  // Unit side: accepts requests, produces results
  modport slave (
    input  A, B, op, start,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit_twos_negate.sv
// rtl/mul_div_unit_twos_negate.sv - width-parameterised conditional two's complement negate
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  // Most negative value maps onto itself, which is the intended mod-2^WIDTH behaviour
  assign y_o = neg_i ? (~x_i + WIDTH'(1)) : x_i;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave mdu
);

  // Controller and datapath state
  mdu_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 is_div_q;
  logic                 sa_q;
  logic                 sb_q;
  logic [WIDTH-1:0]     a_raw_q;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV
  logic [WIDTH-1:0]     mcand_q;
  // MUL: {acc, multiplier}; DIV: {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   work_q;
  logic [2*WIDTH-1:0]   work_d;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 dbz_q;

  // Operand decode and magnitudes
  logic                 req_signed;
  logic                 req_div;
  logic                 neg_a;
  logic                 neg_b;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  assign req_signed = op_is_signed(mdu.op);
  assign req_div    = op_is_div(mdu.op);
  assign neg_a      = req_signed & mdu.A[WIDTH-1];
  assign neg_b      = req_signed & mdu.B[WIDTH-1];

  twos_negate #(.WIDTH(WIDTH)) u_abs_a (
    .x_i   (mdu.A),
    .neg_i (neg_a),
    .y_o   (abs_a)
  );

  twos_negate #(.WIDTH(WIDTH)) u_abs_b (
    .x_i   (mdu.B),
    .neg_i (neg_b),
    .y_o   (abs_b)
  );

  // One iteration step
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_next;

  // Shift-add multiply or restoring divide step on the shared work register
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    trial    = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_ge   = (trial >= {1'b0, mcand_q});
    // When trial >= divisor the true difference is below 2^WIDTH, so low bits suffice
    div_diff = trial[WIDTH-1:0] - mcand_q;
    rem_next = div_ge ? div_diff : trial[WIDTH-1:0];
    work_d   = work_q;
    if (is_div_q) begin
      work_d = {rem_next, work_q[WIDTH-2:0], div_ge};
    end else if (work_q[0]) begin
      work_d = {mul_sum, work_q[WIDTH-1:1]};
    end else begin
      work_d = {1'b0, work_q[2*WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step result
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  twos_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .x_i   (work_d),
    .neg_i (sa_q ^ sb_q),
    .y_o   (prod_fix)
  );

  twos_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .x_i   (work_d[WIDTH-1:0]),
    .neg_i (sa_q ^ sb_q),
    .y_o   (quo_fix)
  );

  // Remainder follows the dividend's sign
  twos_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .x_i   (work_d[2*WIDTH-1:WIDTH]),
    .neg_i (sa_q),
    .y_o   (rem_fix)
  );

  // Controller: accept in IDLE/DONE, iterate in RUN, publish results on the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_raw_q  <= '0;
      mcand_q  <= '0;
      work_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (mdu.start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= req_div;
            sa_q     <= neg_a;
            sb_q     <= neg_b;
            a_raw_q  <= mdu.A;
            dbz_q    <= 1'b0;
            if (req_div) begin
              mcand_q <= abs_b;
              work_q  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              mcand_q <= abs_a;
              work_q  <= {{WIDTH{1'b0}}, abs_b};
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!is_div_q) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (mcand_q == '0) begin
              hi_q  <= a_raw_q;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy        = busy_q;
  assign mdu.done        = done_q;
  assign mdu.hi          = hi_q;
  assign mdu.lo          = lo_q;
  assign mdu.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against an arithmetic reference
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  mul_div_unit_if #(.WIDTH(32)) mdu_if ();

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit / native integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    int                ai;
    int                bi;
    longint            sa;
    longint            sb;
    longint            sp;
    longint unsigned   up;
    ai = a;
    bi = b;
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      2'b00: begin
        sa = ai;
        sb = bi;
        sp = sa * sb;
        h  = sp[63:32];
        l  = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        h  = up[63:32];
        l  = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
          z = 1'b1;
        end else if (op == 2'b11) begin
          l = a / b;
          h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          l = ai / bi;
          h = ai % bi;
        end
      end
    endcase
  endfunction

  // Issue one operation and check timing, hold behaviour and the result
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    logic        ez;
    int          nbusy;
    int          ndone;
    int          nunstable;
    model(op, a, b, eh, el, ez);
    mdu_if.op    = op;
    mdu_if.A     = a;
    mdu_if.B     = b;
    mdu_if.start = 1'b1;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    mdu_if.A     = $urandom;
    mdu_if.B     = $urandom;
    mdu_if.op    = 2'($urandom);
    nbusy     = 0;
    ndone     = 0;
    nunstable = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (mdu_if.busy === 1'b1) nbusy++;
      if (mdu_if.done !== 1'b0) ndone++;
      if (mdu_if.hi !== cur_hi || mdu_if.lo !== cur_lo || mdu_if.div_by_zero !== 1'b0) nunstable++;
      if (poke) mdu_if.start = (i >= 3 && i < 20);
    end
    @(negedge clk);
    chk({tag, " busy_cycles"}, nbusy, 32);
    chk({tag, " early_done"}, ndone, 0);
    chk({tag, " hold_during_run"}, nunstable, 0);
    chk({tag, " done"}, mdu_if.done, 1'b1);
    chk({tag, " busy_at_done"}, mdu_if.busy, 1'b0);
    chk({tag, " hi"}, mdu_if.hi, eh);
    chk({tag, " lo"}, mdu_if.lo, el);
    chk({tag, " div_by_zero"}, mdu_if.div_by_zero, ez);
    cur_hi = eh;
    cur_lo = el;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle done", mdu_if.done, 1'b0);
      chk("idle busy", mdu_if.busy, 1'b0);
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          nd;

    reset        = 1'b1;
    mdu_if.start = 1'b0;
    mdu_if.A     = '0;
    mdu_if.B     = '0;
    mdu_if.op    = '0;
    cur_hi       = '0;
    cur_lo       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", mdu_if.busy, 1'b0);
    chk("reset done", mdu_if.done, 1'b0);
    chk("reset hi", mdu_if.hi, 32'd0);
    chk("reset lo", mdu_if.lo, 32'd0);
    chk("reset dbz", mdu_if.div_by_zero, 1'b0);
    reset = 1'b0;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, "mult_7_m3");
    idle(2);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    idle(1);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, "div_by_zero");
    idle(1);
    run_op(2'b00, 32'd2, 32'd3, 1'b0, "mult_after_dbz");
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "multu_start_in_run");
    run_op(2'b10, 32'h8000_0000, 32'd3, 1'b0, "div_minint_3");
    run_op(2'b11, 32'h8000_0000, 32'd0, 1'b0, "divu_by_zero");

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(rop, ra, rb, bit'($urandom_range(0, 1)), "random");
      nd = $urandom_range(0, 2);
      if (nd > 0) idle(nd);
    end

    // Abort a running operation with reset
    idle(1);
    mdu_if.op    = 2'b00;
    mdu_if.A     = 32'd12345;
    mdu_if.B     = 32'd678;
    mdu_if.start = 1'b1;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", mdu_if.busy, 1'b0);
    chk("abort done", mdu_if.done, 1'b0);
    chk("abort hi", mdu_if.hi, 32'd0);
    chk("abort lo", mdu_if.lo, 32'd0);
    chk("abort dbz", mdu_if.div_by_zero, 1'b0);
    cur_hi = '0;
    cur_lo = '0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (mdu_if.done !== 1'b0 || mdu_if.busy !== 1'b0) nd++;
    end
    chk("abort no_done", nd, 0);

    // Reset wins over a simultaneous start
    mdu_if.start = 1'b1;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    chk("reset_vs_start busy", mdu_if.busy, 1'b0);
    idle(2);

    run_op(2'b11, 32'hDEAD_BEEF, 32'd16, 1'b0, "divu_after_reset");
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
